// File: rtl/id_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_stage_reg : ARM-subset instruction decode, register file, ID/EXE reg    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module id_stage_reg #(
  parameter int DATA_W    = 32,
  parameter int REG_CNT   = 16,
  parameter bit BYPASS_WB = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  input  logic              instr_valid,
  input  logic              hazard,
  input  logic              flush,
  input  logic [3:0]        SR,
  input  logic              writeBackEn,
  input  logic [3:0]        dest_wb,
  input  logic [DATA_W-1:0] Result_WB,
  output logic [3:0]        src1,
  output logic [3:0]        src2,
  output logic              Two_src,
  output logic              ex_valid,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              B,
  output logic              S,
  output logic [3:0]        exe_cmd,
  output logic [DATA_W-1:0] Val_Rn,
  output logic [DATA_W-1:0] Val_Rm,
  output logic              imm,
  output logic [11:0]       shift_operand,
  output logic [23:0]       signed_imm_24,
  output logic [3:0]        Dest,
  output logic [3:0]        ex_src1,
  output logic [3:0]        ex_src2
);

  localparam int c_IDX_W = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;

  logic [1:0]        w_mode;
  logic [3:0]        w_opcode;
  logic              w_store;
  logic              w_cond_ok;
  logic              w_bubble;
  logic              w_wb_in_range;
  logic              w_wb_en, w_mem_r, w_mem_w, w_b, w_s;
  logic [3:0]        w_exe_cmd;
  logic [DATA_W-1:0] w_rn, w_rm;
  logic [DATA_W-1:0] r_regs [REG_CNT];

  assign w_mode   = instruction[27:26];
  assign w_opcode = instruction[24:21];
  assign w_store  = (w_mode == 2'b01) && !instruction[20];

  assign src1    = instruction[19:16];
  assign src2    = w_store ? instruction[15:12] : instruction[3:0];
  assign Two_src = instr_valid && (!instruction[25] || w_store);

  // SR = {N,Z,C,V}
  always_comb begin
    w_cond_ok = 1'b0;
    case (instruction[31:28])
      4'b0000: w_cond_ok = SR[2];
      4'b0001: w_cond_ok = !SR[2];
      4'b0010: w_cond_ok = SR[1];
      4'b0011: w_cond_ok = !SR[1];
      4'b0100: w_cond_ok = SR[3];
      4'b0101: w_cond_ok = !SR[3];
      4'b0110: w_cond_ok = SR[0];
      4'b0111: w_cond_ok = !SR[0];
      4'b1000: w_cond_ok = SR[1] && !SR[2];
      4'b1001: w_cond_ok = !SR[1] || SR[2];
      4'b1010: w_cond_ok = (SR[3] == SR[0]);
      4'b1011: w_cond_ok = (SR[3] != SR[0]);
      4'b1100: w_cond_ok = !SR[2] && (SR[3] == SR[0]);
      4'b1101: w_cond_ok = SR[2] || (SR[3] != SR[0]);
      4'b1110: w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_exe_cmd = 4'b0000;
    w_wb_en   = 1'b0;
    w_mem_r   = 1'b0;
    w_mem_w   = 1'b0;
    w_b       = 1'b0;
    w_s       = 1'b0;
    case (w_mode)
      2'b00: begin
        w_s     = instruction[20];
        w_wb_en = 1'b1;
        case (w_opcode)
          4'b1101: w_exe_cmd = 4'b0001;
          4'b1111: w_exe_cmd = 4'b1001;
          4'b0100: w_exe_cmd = 4'b0010;
          4'b0101: w_exe_cmd = 4'b0011;
          4'b0010: w_exe_cmd = 4'b0100;
          4'b0110: w_exe_cmd = 4'b0101;
          4'b0000: w_exe_cmd = 4'b0110;
          4'b1100: w_exe_cmd = 4'b0111;
          4'b0001: w_exe_cmd = 4'b1000;
          4'b1010: begin w_exe_cmd = 4'b0100; w_wb_en = 1'b0; end
          4'b1000: begin w_exe_cmd = 4'b0110; w_wb_en = 1'b0; end
          default: begin w_s = 1'b0; w_wb_en = 1'b0; end
        endcase
      end
      2'b01: begin
        w_exe_cmd = 4'b0010;
        if (instruction[20]) begin
          w_mem_r = 1'b1;
          w_wb_en = 1'b1;
        end else begin
          w_mem_w = 1'b1;
        end
      end
      2'b10:   w_b = 1'b1;
      default: ;
    endcase
  end

  assign w_bubble      = flush || hazard || !instr_valid || !w_cond_ok;
  assign w_wb_in_range = ({1'b0, dest_wb} < 5'(REG_CNT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) r_regs[i] <= '0;
    end else if (writeBackEn && w_wb_in_range) begin
      r_regs[dest_wb[c_IDX_W-1:0]] <= Result_WB;
    end
  end

  // Bypass only on a write that actually lands in the file.
  generate
    if (BYPASS_WB) begin : g_bypass
      logic w_hit_rn, w_hit_rm;
      assign w_hit_rn = writeBackEn && w_wb_in_range && (dest_wb[c_IDX_W-1:0] == src1[c_IDX_W-1:0]);
      assign w_hit_rm = writeBackEn && w_wb_in_range && (dest_wb[c_IDX_W-1:0] == src2[c_IDX_W-1:0]);
      assign w_rn = w_hit_rn ? Result_WB : r_regs[src1[c_IDX_W-1:0]];
      assign w_rm = w_hit_rm ? Result_WB : r_regs[src2[c_IDX_W-1:0]];
    end else begin : g_no_bypass
      assign w_rn = r_regs[src1[c_IDX_W-1:0]];
      assign w_rm = r_regs[src2[c_IDX_W-1:0]];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      wb_en         <= 1'b0;
      mem_r_en      <= 1'b0;
      mem_w_en      <= 1'b0;
      B             <= 1'b0;
      S             <= 1'b0;
      exe_cmd       <= 4'b0000;
      Val_Rn        <= '0;
      Val_Rm        <= '0;
      imm           <= 1'b0;
      shift_operand <= 12'h000;
      signed_imm_24 <= 24'h000000;
      Dest          <= 4'h0;
      ex_src1       <= 4'h0;
      ex_src2       <= 4'h0;
    end else begin
      ex_valid      <= !w_bubble;
      wb_en         <= w_bubble ? 1'b0 : w_wb_en;
      mem_r_en      <= w_bubble ? 1'b0 : w_mem_r;
      mem_w_en      <= w_bubble ? 1'b0 : w_mem_w;
      B             <= w_bubble ? 1'b0 : w_b;
      S             <= w_bubble ? 1'b0 : w_s;
      exe_cmd       <= w_bubble ? 4'b0000 : w_exe_cmd;
      Val_Rn        <= w_rn;
      Val_Rm        <= w_rm;
      imm           <= instruction[25];
      shift_operand <= instruction[11:0];
      signed_imm_24 <= instruction[23:0];
      Dest          <= instruction[15:12];
      ex_src1       <= src1;
      ex_src2       <= src2;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_id_stage_reg : scoreboard bench for id_stage_reg (bypass and no-bypass) |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_id_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction = '0;
  logic        instr_valid = 1'b0, hazard = 1'b0, flush = 1'b0;
  logic [3:0]  sr = 4'h0;
  logic        writeBackEn = 1'b0;
  logic [3:0]  dest_wb = 4'h0;
  logic [31:0] Result_WB = '0;

  logic [3:0]  src1, src2, exe_cmd, Dest, ex_src1, ex_src2;
  logic        Two_src, ex_valid, wb_en, mem_r_en, mem_w_en, B, S, imm;
  logic [31:0] Val_Rn, Val_Rm;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;

  logic [3:0]  nb_src1, nb_src2, nb_exe_cmd, nb_Dest, nb_ex_src1, nb_ex_src2;
  logic        nb_Two_src, nb_ex_valid, nb_wb_en, nb_mem_r_en, nb_mem_w_en, nb_B, nb_S, nb_imm;
  logic [31:0] nb_Val_Rn, nb_Val_Rm;
  logic [11:0] nb_shift_operand;
  logic [23:0] nb_signed_imm_24;

  always #5 clk = ~clk;

  id_stage_reg #(.DATA_W(32), .REG_CNT(16), .BYPASS_WB(1'b1)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
    .hazard(hazard), .flush(flush), .SR(sr), .writeBackEn(writeBackEn),
    .dest_wb(dest_wb), .Result_WB(Result_WB), .src1(src1), .src2(src2),
    .Two_src(Two_src), .ex_valid(ex_valid), .wb_en(wb_en), .mem_r_en(mem_r_en),
    .mem_w_en(mem_w_en), .B(B), .S(S), .exe_cmd(exe_cmd), .Val_Rn(Val_Rn),
    .Val_Rm(Val_Rm), .imm(imm), .shift_operand(shift_operand),
    .signed_imm_24(signed_imm_24), .Dest(Dest), .ex_src1(ex_src1), .ex_src2(ex_src2)
  );

  id_stage_reg #(.DATA_W(32), .REG_CNT(16), .BYPASS_WB(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
    .hazard(hazard), .flush(flush), .SR(sr), .writeBackEn(writeBackEn),
    .dest_wb(dest_wb), .Result_WB(Result_WB), .src1(nb_src1), .src2(nb_src2),
    .Two_src(nb_Two_src), .ex_valid(nb_ex_valid), .wb_en(nb_wb_en), .mem_r_en(nb_mem_r_en),
    .mem_w_en(nb_mem_w_en), .B(nb_B), .S(nb_S), .exe_cmd(nb_exe_cmd), .Val_Rn(nb_Val_Rn),
    .Val_Rm(nb_Val_Rm), .imm(nb_imm), .shift_operand(nb_shift_operand),
    .signed_imm_24(nb_signed_imm_24), .Dest(nb_Dest), .ex_src1(nb_ex_src1), .ex_src2(nb_ex_src2)
  );

  // ctrl = {ex_valid, wb_en, mem_r_en, mem_w_en, B, S, exe_cmd}
  typedef struct {
    logic [9:0]  ctrl;
    logic        chk_src;
    logic [3:0]  s1, s2;
    logic        two;
    logic        chk_data;
    logic [31:0] rn, rm, rm_nb;
    logic [3:0]  dst;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic exp_t mk(logic [9:0] c, logic cs, logic [3:0] s1, logic [3:0] s2, logic two,
                              logic cd, logic [31:0] rn, logic [31:0] rm, logic [31:0] rm_nb,
                              logic [3:0] dst);
    exp_t e;
    e.ctrl = c; e.chk_src = cs; e.s1 = s1; e.s2 = s2; e.two = two;
    e.chk_data = cd; e.rn = rn; e.rm = rm; e.rm_nb = rm_nb; e.dst = dst;
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic apply(logic [31:0] ins, logic v, logic h, logic f, logic [3:0] s,
                       logic we, logic [3:0] d, logic [31:0] res, exp_t e);
    @(negedge clk);
    instruction = ins; instr_valid = v; hazard = h; flush = f; sr = s;
    writeBackEn = we; dest_wb = d; Result_WB = res;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    instr_valid = 1'b0; hazard = 1'b0; flush = 1'b0; writeBackEn = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #2;
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Monitor: one expected entry per cycle following each applied vector.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && sb.size() != 0) begin
        e = sb.pop_front();
        chk("ctrl", 32'({ex_valid, wb_en, mem_r_en, mem_w_en, B, S, exe_cmd}), 32'(e.ctrl));
        if (e.chk_src) begin
          chk("src1", 32'(src1), 32'(e.s1));
          chk("src2", 32'(src2), 32'(e.s2));
          chk("Two_src", 32'(Two_src), 32'(e.two));
        end
        if (e.chk_data) begin
          chk("Val_Rn", Val_Rn, e.rn);
          chk("Val_Rm", Val_Rm, e.rm);
          chk("Val_Rm_nobypass", nb_Val_Rm, e.rm_nb);
          chk("Dest", 32'(Dest), 32'(e.dst));
        end
      end
    end
  end

  localparam logic [31:0] c_ADD   = 32'hE0821003;
  localparam logic [31:0] c_ADDEQ = 32'h00821003;
  localparam logic [31:0] c_ADDGT = 32'hC0821003;
  localparam logic [31:0] c_ADDNV = 32'hF0821003;
  localparam logic [31:0] c_RSB   = 32'hE0621003;
  localparam logic [31:0] c_STR   = 32'hE5854000;
  localparam logic [31:0] c_LDR   = 32'hE5956000;
  localparam logic [31:0] c_CMP   = 32'hE1520003;
  localparam logic [31:0] c_BR    = 32'hEA000010;
  localparam logic [31:0] c_MOVI  = 32'hE3A07005;

  initial begin
    exp_t z;
    z = mk(10'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    chk("reset_ctrl", 32'({ex_valid, wb_en, mem_r_en, mem_w_en, B, S, exe_cmd}), 32'h0);
    chk("reset_data", Val_Rn | Val_Rm | 32'(Dest), 32'h0);
    rst = 1'b0;

    // Preload R2=5, R3=7, R4=0x11, R5=0x20 through write-back.
    apply(32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'd2, 32'h5,  z);
    apply(32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'd3, 32'h7,  z);
    apply(32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'd4, 32'h11, z);
    apply(32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'd5, 32'h20, z);

    apply(c_ADD, 1, 0, 0, 4'h0, 0, 4'h0, 32'h0,
          mk(10'b11_0000_0010, 1, 4'd2, 4'd3, 1, 1, 32'h5, 32'h7, 32'h7, 4'd1));
    apply(c_ADD, 1, 1, 0, 4'h0, 0, 4'h0, 32'h0,
          mk(10'b00_0000_0000, 1, 4'd2, 4'd3, 1, 1, 32'h5, 32'h7, 32'h7, 4'd1));
    apply(c_ADD, 1, 0, 0, 4'h0, 0, 4'h0, 32'h0,
          mk(10'b11_0000_0010, 1, 4'd2, 4'd3, 1, 1, 32'h5, 32'h7, 32'h7, 4'd1));
    apply(c_ADDEQ, 1, 0, 0, 4'b0000, 0, 4'h0, 32'h0,
          mk(10'b00_0000_0000, 0, 4'd0, 4'd0, 0, 1, 32'h5, 32'h7, 32'h7, 4'd1));
    apply(c_ADDEQ, 1, 0, 0, 4'b0100, 0, 4'h0, 32'h0,
          mk(10'b11_0000_0010, 0, 4'd0, 4'd0, 0, 1, 32'h5, 32'h7, 32'h7, 4'd1));
    // STR R4,[R5] with a same-cycle write of 0xAA into R4.
    apply(c_STR, 1, 0, 0, 4'h0, 1, 4'd4, 32'hAA,
          mk(10'b10_0100_0010, 1, 4'd5, 4'd4, 1, 1, 32'h20, 32'hAA, 32'h11, 4'd4));
    apply(c_LDR, 1, 0, 0, 4'h0, 0, 4'h0, 32'h0,
          mk(10'b11_1000_0010, 1, 4'd5, 4'd0, 1, 1, 32'h20, 32'h0, 32'h0, 4'd6));
    apply(c_CMP, 1, 1, 1, 4'h0, 0, 4'h0, 32'h0,
          mk(10'b00_0000_0000, 1, 4'd2, 4'd3, 1, 1, 32'h5, 32'h7, 32'h7, 4'd0));
    apply(c_CMP, 1, 0, 0, 4'h0, 0, 4'h0, 32'h0,
          mk(10'b10_0001_0100, 1, 4'd2, 4'd3, 1, 1, 32'h5, 32'h7, 32'h7, 4'd0));
    apply(c_BR, 1, 0, 0, 4'h0, 0, 4'h0, 32'h0,
          mk(10'b10_0010_0000, 1, 4'd0, 4'd0, 0, 1, 32'h0, 32'h0, 32'h0, 4'd0));
    apply(c_MOVI, 1, 0, 0, 4'h0, 0, 4'h0, 32'h0,
          mk(10'b11_0000_0001, 1, 4'd0, 4'd5, 0, 1, 32'h0, 32'h20, 32'h20, 4'd7));
    apply(c_ADD, 0, 0, 0, 4'h0, 0, 4'h0, 32'h0,
          mk(10'b00_0000_0000, 1, 4'd2, 4'd3, 0, 1, 32'h5, 32'h7, 32'h7, 4'd1));
    apply(c_ADDNV, 1, 0, 0, 4'hF, 0, 4'h0, 32'h0,
          mk(10'b00_0000_0000, 0, 4'd0, 4'd0, 0, 1, 32'h5, 32'h7, 32'h7, 4'd1));
    apply(c_RSB, 1, 0, 0, 4'h0, 0, 4'h0, 32'h0,
          mk(10'b10_0000_0000, 0, 4'd0, 4'd0, 0, 1, 32'h5, 32'h7, 32'h7, 4'd1));
    apply(c_ADDGT, 1, 0, 0, 4'b0000, 0, 4'h0, 32'h0,
          mk(10'b11_0000_0010, 0, 4'd0, 4'd0, 0, 0, 32'h0, 32'h0, 32'h0, 4'd0));
    apply(c_ADDGT, 1, 0, 0, 4'b1000, 0, 4'h0, 32'h0,
          mk(10'b00_0000_0000, 0, 4'd0, 4'd0, 0, 0, 32'h0, 32'h0, 32'h0, 4'd0));
    apply(c_ADD, 1, 0, 0, 4'h0, 0, 4'h0, 32'h0,
          mk(10'b11_0000_0010, 0, 4'd0, 4'd0, 0, 1, 32'h5, 32'h7, 32'h7, 4'd1));

    // Mid-cycle reset while the ADD is held in the ID/EXE register.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_reset_ctrl", 32'({ex_valid, wb_en, mem_r_en, mem_w_en, B, S, exe_cmd}), 32'h0);
    chk("async_reset_data", Val_Rn | Val_Rm | 32'(Dest), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    apply(c_ADD, 1, 0, 0, 4'h0, 0, 4'h0, 32'h0,
          mk(10'b11_0000_0010, 1, 4'd2, 4'd3, 1, 1, 32'h0, 32'h0, 32'h0, 4'd1));
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_stage_reg.md
ID_STAGE_REG -- requirements
Module: id_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, register and operand data width.
REQ-002 Parameter REG_CNT, default 16, number of architectural registers (power of two, 2..16; register index field stays 4 bits, upper unused index bits ignored).
REQ-003 Parameter BYPASS_WB, default 1, 1 = same-cycle write-back-to-read bypass, 0 = no bypass.
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 instruction  in  32  instruction from IF/ID register.
REQ-007 instr_valid  in  1  instruction slot holds a real instruction.
REQ-008 hazard  in  1  hazard unit requests a bubble this cycle.
REQ-009 flush  in  1  taken branch in EXE; kill the instruction being decoded.
REQ-010 SR  in  4  status flags {N,Z,C,V} in bits [3:0].
REQ-011 writeBackEn, dest_wb, Result_WB  in  1/4/DATA_W  write-back port.
REQ-012 src1, src2  out  4  combinational source indices to hazard unit; Two_src out 1.
REQ-013 Registered outputs (ID/EXE): ex_valid 1, wb_en, mem_r_en, mem_w_en, B, S each 1, exe_cmd 4, Val_Rn and Val_Rm DATA_W, imm 1, shift_operand 12, signed_imm_24 24, Dest 4, ex_src1, ex_src2 4.

Function
REQ-014 src1 = instruction[19:16]; src2 = instruction[15:12] when decoded store (mode 01, bit20 = 0), else instruction[3:0].
REQ-015 Two_src = 1 when imm (instruction[25]) = 0 or decoded store; gated to 0 when instr_valid = 0.
REQ-016 Decode, mode = instruction[27:26], opcode = instruction[24:21]: mode 00 maps MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000, CMP 1010->0100, TST 1000->0110; wb_en = 1 except CMP/TST; S = instruction[20].
REQ-017 Mode 01: exe_cmd 0010; bit20 = 1 gives LDR (mem_r_en = 1, wb_en = 1), bit20 = 0 gives STR (mem_w_en = 1); S = 0.
REQ-018 Mode 10: B = 1, all other controls 0; mode 11 or unlisted opcode: all controls 0 (NOP).
REQ-019 Condition check on instruction[31:28] against SR per ARM codes EQ..AL (0000..1110); 1111 evaluates false.
REQ-020 Register file REG_CNT x DATA_W written at rising edge when writeBackEn = 1 and dest_wb < REG_CNT; reads combinational.
REQ-021 With BYPASS_WB = 1, a read whose index equals dest_wb while writeBackEn = 1 returns Result_WB in the same cycle; BYPASS_WB = 0 returns old contents.
REQ-022 Bubble condition = hazard | flush | ~instr_valid | condition false; on bubble the next ex_valid = 0 and wb_en, mem_r_en, mem_w_en, B, S, exe_cmd load 0; data fields load normally.
REQ-023 Otherwise all registered outputs load decoded values and ex_valid = 1; one-cycle latency instruction -> outputs.
REQ-024 flush has priority over hazard; simultaneous write-back and bubble both take effect.

Reset
REQ-025 rst asserted, mid-operation included, immediately clears every registered output and all register-file entries to 0; first valid decode appears one cycle after rst deasserts with a valid instruction.

Verification
REQ-026 ADD R1,R2,R3 (0xE0821003), R2 = 5, R3 = 7, instr_valid = 1 -> next cycle ex_valid = 1, exe_cmd 0010, wb_en 1, Val_Rn 5, Val_Rm 7, Dest 1.
REQ-027 Same ADD with hazard = 1 -> ex_valid 0, all controls 0; hold hazard 0 next cycle -> controls re-issued.
REQ-028 ADDEQ with SR = 0000 -> bubble; with SR = 0100 -> wb_en 1.
REQ-029 STR R4,[R5] with writeBackEn = 1, dest_wb = 4, Result_WB = 0xAA same cycle -> Val_Rm 0xAA (BYPASS_WB = 1), old value (BYPASS_WB = 0); src2 = 4, Two_src 1.
REQ-030 CMP with flush = 1 and hazard = 1 -> bubble; then CMP unflushed -> exe_cmd 0100, wb_en 0, S 1.
REQ-031 rst pulsed while valid outputs held -> all outputs 0 asynchronously, register reads 0 after release.
